// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Takes a byte stream (LEN, N big-endian 16-bit words, XOR checksum) over a
// valid/ready link and writes the words sequentially from address 0.
// The CPU is held in reset from power-up until a load completes with a good
// checksum.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_load,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_WRITE = 3'd4,
      S_CSUM  = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   // A LEN byte of zero stands for a full-depth load, which needs one more
   // bit than the address to count.
   localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_WORD   = (ADDR_W+1)'(1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [7:0]        csum;
   logic [7:0]        hi_byte;
   logic              accept;

   assign accept    = rx_valid && rx_ready;
   assign state_dbg = state;

   // Session sequencer: every output is registered and updated alongside
   // the state, so rx_ready is raised on entry to each byte-consuming state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         csum      <= '0;
         hi_byte   <= '0;
         rx_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_load) begin
                  state    <= S_LEN;
                  rx_ready <= 1'b1;
                  addr     <= '0;
                  csum     <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_LEN: begin
               if (accept) begin
                  remaining <= (rx_data == 8'd0) ? FULL_DEPTH : (ADDR_W+1)'(rx_data);
                  state     <= S_HI;
               end
            end
            S_HI: begin
               if (accept) begin
                  hi_byte <= rx_data;
                  csum    <= csum ^ rx_data;
                  state   <= S_LO;
               end
            end
            S_LO: begin
               if (accept) begin
                  csum      <= csum ^ rx_data;
                  mem_addr  <= addr;
                  mem_wdata <= DATA_W'({hi_byte, rx_data});
                  mem_we    <= 1'b1;
                  rx_ready  <= 1'b0;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               addr      <= addr + ADDR_W'(1);
               remaining <= remaining - ONE_WORD;
               rx_ready  <= 1'b1;
               state     <= (remaining == ONE_WORD) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (rx_data == csum) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     err   <= 1'b1;
                     state <= S_ERR;
                  end
               end
            end
            default: begin
               rx_ready <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. It receives a byte stream over a valid/ready link (fed by the UART receiver), assembles 16-bit instruction words, and writes them sequentially into the CPU instruction ROM's write port. While loading it holds the CPU in reset, and it checks the stream with an XOR checksum. The CPU fetches from the same memory only after the loader reports done.

Parameters:
ADDR_W, 8, instruction memory address width; depth is 2**ADDR_W words.
DATA_W, 16, instruction word width; fixed at 16, two bytes per word.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
start_load  in  1  single-cycle pulse that begins a load session.
rx_valid  in  1  byte available on rx_data.
rx_data  in  8  incoming byte.
rx_ready  out  1  loader accepts a byte when rx_valid && rx_ready.
mem_we  out  1  instruction memory write strobe, one cycle per word.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  DATA_W  write data.
cpu_hold  out  1  holds the CPU in reset while high.
busy  out  1  session in progress.
done  out  1  sticky: last session finished with a good checksum.
err  out  1  sticky: last session failed the checksum.
state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (async assert, sync release); all outputs take these values:
  - state=S_IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, err=0.
  - The CPU stays held until the first successful load.
- Stream format:
  - LEN byte N: word count; N=0 means 2**ADDR_W words.
  - N words, each high byte then low byte.
  - CSUM byte: XOR of every data byte, LEN excluded.
- State encoding: S_IDLE=0, S_LEN=1, S_HI=2, S_LO=3, S_WRITE=4, S_CSUM=5, S_DONE=6, S_ERR=7.
- S_IDLE/S_DONE/S_ERR, start_load=1:
  - Next cycle enter S_LEN.
  - Clear done, err, addr counter and checksum accumulator; set cpu_hold=1, busy=1.
- S_LEN: rx_ready=1. On handshake, latch remaining = (N==0 ? 2**ADDR_W : N) (ADDR_W+1 bits), then go to S_HI.
- S_HI: rx_ready=1. On handshake, latch the high byte, csum ^= byte, go to S_LO.
- S_LO: rx_ready=1. On handshake, latch the low byte, csum ^= byte, go to S_WRITE.
- S_WRITE: exactly one cycle.
  - rx_ready=0, mem_we=1, mem_addr=addr, mem_wdata={hi,lo}.
  - Next cycle: addr+1 (wraps mod 2**ADDR_W), remaining-1.
  - Go to S_CSUM if remaining was 1, else S_HI.
- S_CSUM: rx_ready=1. On handshake:
  - byte==csum -> S_DONE: done=1, busy=0, cpu_hold=0.
  - mismatch -> S_ERR: err=1, busy=0, cpu_hold stays 1.
- Outside S_LEN/S_HI/S_LO/S_CSUM, rx_ready=0. Bytes arriving then are not consumed, and rx_valid is ignored.
- start_load while busy is ignored; there is no restart mid-session.
- mem_we is high only in S_WRITE. mem_addr/mem_wdata hold their last values otherwise.
- Write latency: the memory write happens on the 1st cycle after the low-byte handshake.
- Minimum session: 2 + 3N + 1 cycles when rx_valid is held high.
- Full-depth load (N=0): 256 writes to addresses 0..255; addr wraps to 0 and is unused afterwards.
- A stalled stream (rx_valid low) waits indefinitely in the current state. There is no timeout in this block.
- reset_n asserted mid-session:
  - Immediate return to reset values.
  - Any partially written memory contents remain.
  - cpu_hold=1.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, rx_ready=0, mem_we=0, done=0, err=0, state_dbg=0.
- start_load; stream 03,11,11,22,22,33,33,00 with rx_valid held high -> mem_we pulses at addr 0,1,2 with data 1111,2222,3333. The CSUM byte 00 matches (XOR of the six data bytes is 00), so done=1, cpu_hold=0 by cycle 2+9+1 after start.
- Same stream but CSUM=5A -> three writes occur, then err=1, done=0, cpu_hold stays 1, state_dbg=7.
- N=00 with 512 bytes of incrementing words -> 256 writes covering addresses 00..FF. Writes happen only when the remaining count is nonzero. After the CSUM byte, done=1.
- Random rx_valid gaps, plus start_load pulsed mid-session -> write data and addresses match the gapless case, and the second start_load has no effect.
- reset_n dropped asynchronously during S_LO -> all outputs return to reset values without waiting for a clock edge. A new start_load after release then loads correctly from address 0.
